// File: rtl/div_unit_pkg.sv
// Shared types and constants for the integer divider slice.
// Holds the reset/enable/data types used on the HI/LO write port, the divider
// state encoding, and the signedness selector constants.
package div_unit_pkg;

  localparam int DATA_W = 32;

  typedef logic reset_status_t;
  localparam reset_status_t RST_ENABLE  = 1'b1;
  localparam reset_status_t RST_DISABLE = 1'b0;

  typedef logic reg_en_t;
  localparam reg_en_t REG_ENABLE  = 1'b1;
  localparam reg_en_t REG_DISABLE = 1'b0;

  typedef logic [DATA_W-1:0] reg_data_t;

  // One quotient bit is retired per cycle, so the iteration count equals the data width.
  localparam int DIV_CYCLES = DATA_W;

  localparam logic DIV_SIGNED   = 1'b1;
  localparam logic DIV_UNSIGNED = 1'b0;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BY_ZERO,
    DIV_ON,
    DIV_END
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Issue/result bundle between the EX stage and the divider.
// master: EX side (drives start/signedness/annul/operands, observes busy and
//         the HI/LO write port).
// slave : divider side (the opposite directions).
interface div_unit_if;
  import div_unit_pkg::*;

  logic      start_i;
  logic      signed_i;
  logic      annul_i;
  reg_data_t dividend_i;
  reg_data_t divisor_i;
  logic      busy_o;
  reg_en_t   hilo_write_en_o;
  reg_data_t hi_data_o;
  reg_data_t lo_data_o;

  modport master (
    output start_i, signed_i, annul_i, dividend_i, divisor_i,
    input  busy_o, hilo_write_en_o, hi_data_o, lo_data_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, dividend_i, divisor_i,
    output busy_o, hilo_write_en_o, hi_data_o, lo_data_o
  );

endinterface

// File: rtl/div_unit_step.sv
// div_step: one combinational iteration of restoring radix-2 division.
// Ports:
//   part_rem_i : shifted partial remainder (WIDTH+1 bits, so an unsigned
//                divisor with bit WIDTH-1 set still compares correctly)
//   divisor_i  : divisor magnitude
//   next_rem_o : partial remainder after the trial subtraction
//   quo_bit_o  : quotient bit produced by this iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   part_rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] next_rem_o,
  output logic             quo_bit_o
);

  // The result is always strictly below the divisor, so WIDTH bits hold it.
  always_comb begin
    quo_bit_o  = (part_rem_i >= {1'b0, divisor_i});
    next_rem_o = quo_bit_o ? WIDTH'(part_rem_i - {1'b0, divisor_i})
                           : part_rem_i[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle DIV/DIVU unit, writer of the HI/LO register pair.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset (RST_ENABLE clears the block)
//   bus : div_unit_if.slave
//         start_i/signed_i/annul_i/dividend_i/divisor_i from EX,
//         busy_o stalls EX, hilo_write_en_o is a one-cycle pulse carrying
//         hi_data_o (remainder) and lo_data_o (quotient).
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic          clk,
  input  reset_status_t rst,
  div_unit_if.slave     bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       state, state_nxt;
  logic             accept;
  logic             busy;
  reg_en_t          wr_en;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             by_zero_q;
  reg_data_t        hi_q, lo_q;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  reg_data_t        res_hi, res_lo;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    // The most negative value maps onto itself, which reads correctly as an
    // unsigned magnitude.
    return (is_signed && v[WIDTH-1]) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction

  // In the quotient register the dividend bits are shifted out MSB first
  // while quotient bits are shifted in at the bottom.
  div_step #(.WIDTH(WIDTH)) u_step (
    .part_rem_i ({rem_q, quo_q[WIDTH-1]}),
    .divisor_i  (dvs_q),
    .next_rem_o (step_rem),
    .quo_bit_o  (step_bit)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b1;
    wr_en     = REG_DISABLE;
    case (state)
      DIV_IDLE: begin
        busy = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          accept    = 1'b1;
          state_nxt = (bus.divisor_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_BY_ZERO: state_nxt = bus.annul_i ? DIV_IDLE : DIV_END;
      DIV_ON: begin
        if (bus.annul_i) begin
          state_nxt = DIV_IDLE;
        end else if (cnt == CNT_W'(DIV_CYCLES)) begin
          state_nxt = DIV_END;
        end
      end
      DIV_END: begin
        state_nxt = DIV_IDLE;
        // Flush arriving in the write cycle still kills the write.
        if (!bus.annul_i) begin
          wr_en = REG_ENABLE;
        end
      end
      default: state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    if (by_zero_q) begin
      res_lo = '1;
      res_hi = quo_q;
    end else begin
      res_lo = apply_sign(quo_q, neg_quo_q);
      res_hi = apply_sign(rem_q, neg_rem_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      by_zero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (accept) begin
        cnt       <= '0;
        rem_q     <= '0;
        dvs_q     <= magnitude(bus.divisor_i, bus.signed_i);
        by_zero_q <= (bus.divisor_i == '0);
        // Divide by zero returns the dividend exactly as issued.
        quo_q     <= (bus.divisor_i == '0) ? bus.dividend_i
                                           : magnitude(bus.dividend_i, bus.signed_i);
        neg_quo_q <= bus.signed_i & (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]);
        neg_rem_q <= bus.signed_i & bus.dividend_i[WIDTH-1];
      end else if (state == DIV_ON && cnt != CNT_W'(DIV_CYCLES)) begin
        rem_q <= step_rem;
        quo_q <= {quo_q[WIDTH-2:0], step_bit};
        cnt   <= cnt + CNT_W'(1);
      end
      if (wr_en == REG_ENABLE) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign bus.busy_o          = busy;
  assign bus.hilo_write_en_o = wr_en;
  assign bus.hi_data_o       = (wr_en == REG_ENABLE) ? res_hi : hi_q;
  assign bus.lo_data_o       = (wr_en == REG_ENABLE) ? res_lo : lo_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import div_unit_pkg::*;

  logic          clk;
  reset_status_t rst;
  int            tests_run;
  int            fails;

  div_unit_if dif();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer division semantics, quotient truncated toward zero,
  // remainder carrying the dividend's sign, divide by zero fixed result.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] q,
                                  output logic [31:0] r);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one division and wait for its write pulse. cyc is the cycle of the
  // pulse counted from the start cycle (0); cyc==60 means no pulse appeared.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output int cyc, output bit busy_ok);
    @(negedge clk);
    dif.dividend_i = a;
    dif.divisor_i  = b;
    dif.signed_i   = s;
    dif.start_i    = 1'b1;
    @(negedge clk);
    dif.start_i = 1'b0;
    cyc     = 1;
    busy_ok = 1'b1;
    while (cyc < 60 && dif.hilo_write_en_o !== REG_ENABLE) begin
      if (dif.busy_o !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (dif.busy_o !== 1'b1) busy_ok = 1'b0;
    hi = dif.hi_data_o;
    lo = dif.lo_data_o;
  endtask

  task automatic test_reset();
    rst = RST_ENABLE;
    repeat (3) @(negedge clk);
    tests_run++;
    if (dif.busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", dif.busy_o); end
    tests_run++;
    if (dif.hilo_write_en_o !== REG_DISABLE) begin fails++; $display("FAIL reset_we: got %b want 0", dif.hilo_write_en_o); end
    tests_run++;
    if (dif.hi_data_o !== 32'd0) begin fails++; $display("FAIL reset_hi: got %h want 0", dif.hi_data_o); end
    tests_run++;
    if (dif.lo_data_o !== 32'd0) begin fails++; $display("FAIL reset_lo: got %h want 0", dif.lo_data_o); end
    rst = RST_DISABLE;
  endtask

  task automatic test_divu_basic();
    logic [31:0] hi, lo;
    int cyc;
    bit bok;
    run_div(32'd7, 32'd2, DIV_UNSIGNED, hi, lo, cyc, bok);
    tests_run++;
    if (cyc !== 34) begin fails++; $display("FAIL divu_latency: got cycle %0d want 34", cyc); end
    tests_run++;
    if (bok !== 1'b1) begin fails++; $display("FAIL divu_busy: busy dropped early, got %b want 1", bok); end
    tests_run++;
    if (lo !== 32'd3) begin fails++; $display("FAIL divu_lo: got %h want 3", lo); end
    tests_run++;
    if (hi !== 32'd1) begin fails++; $display("FAIL divu_hi: got %h want 1", hi); end
    @(negedge clk);
    tests_run++;
    if (dif.busy_o !== 1'b0 || dif.hilo_write_en_o !== REG_DISABLE) begin
      fails++; $display("FAIL divu_after: got busy %b we %b want 0 0", dif.busy_o, dif.hilo_write_en_o);
    end
    tests_run++;
    if (dif.lo_data_o !== 32'd3 || dif.hi_data_o !== 32'd1) begin
      fails++; $display("FAIL divu_hold: got lo %h hi %h want 3 1", dif.lo_data_o, dif.hi_data_o);
    end
  endtask

  task automatic test_corner_cases();
    logic [31:0] ta [8];
    logic [31:0] tb [8];
    logic        ts [8];
    logic [31:0] tq [8];
    logic [31:0] tr [8];
    int          tc [8];
    logic [31:0] hi, lo;
    int cyc;
    bit bok;
    ta[0] = 32'hFFFF_FFF9; tb[0] = 32'd2;          ts[0] = 1; tq[0] = 32'hFFFF_FFFD; tr[0] = 32'hFFFF_FFFF; tc[0] = 34;
    ta[1] = 32'd7;         tb[1] = 32'hFFFF_FFFE;  ts[1] = 1; tq[1] = 32'hFFFF_FFFD; tr[1] = 32'd1;         tc[1] = 34;
    ta[2] = 32'd5;         tb[2] = 32'd0;          ts[2] = 1; tq[2] = 32'hFFFF_FFFF; tr[2] = 32'd5;         tc[2] = 2;
    ta[3] = 32'd5;         tb[3] = 32'd0;          ts[3] = 0; tq[3] = 32'hFFFF_FFFF; tr[3] = 32'd5;         tc[3] = 2;
    ta[4] = 32'h8000_0000; tb[4] = 32'hFFFF_FFFF;  ts[4] = 1; tq[4] = 32'h8000_0000; tr[4] = 32'd0;         tc[4] = 34;
    ta[5] = 32'hFFFF_FFFF; tb[5] = 32'd1;          ts[5] = 0; tq[5] = 32'hFFFF_FFFF; tr[5] = 32'd0;         tc[5] = 34;
    ta[6] = 32'hFFFF_FFFB; tb[6] = 32'd0;          ts[6] = 1; tq[6] = 32'hFFFF_FFFF; tr[6] = 32'hFFFF_FFFB; tc[6] = 2;
    ta[7] = 32'hFFFF_FFFE; tb[7] = 32'hFFFF_FFFF;  ts[7] = 0; tq[7] = 32'd0;         tr[7] = 32'hFFFF_FFFE; tc[7] = 34;
    for (int i = 0; i < 8; i++) begin
      run_div(ta[i], tb[i], ts[i], hi, lo, cyc, bok);
      tests_run++;
      if (cyc !== tc[i]) begin fails++; $display("FAIL corner%0d_latency: got cycle %0d want %0d", i, cyc, tc[i]); end
      tests_run++;
      if (lo !== tq[i]) begin fails++; $display("FAIL corner%0d_lo: got %h want %h", i, lo, tq[i]); end
      tests_run++;
      if (hi !== tr[i]) begin fails++; $display("FAIL corner%0d_hi: got %h want %h", i, hi, tr[i]); end
    end
  endtask

  task automatic test_annul();
    int pulses;
    @(negedge clk);
    dif.dividend_i = 32'd1000; dif.divisor_i = 32'd3; dif.signed_i = 1'b0; dif.start_i = 1'b1;
    @(negedge clk);
    dif.start_i = 1'b0;
    pulses = 0;
    for (int c = 1; c < 10; c++) begin
      if (dif.hilo_write_en_o === REG_ENABLE) pulses++;
      @(negedge clk);
    end
    dif.annul_i = 1'b1;               // cycle 10
    if (dif.hilo_write_en_o === REG_ENABLE) pulses++;
    @(negedge clk);                   // cycle 11
    dif.annul_i = 1'b0;
    tests_run++;
    if (dif.busy_o !== 1'b0) begin fails++; $display("FAIL annul_busy: got %b want 0", dif.busy_o); end
    dif.dividend_i = 32'd100; dif.divisor_i = 32'd7; dif.signed_i = 1'b0; dif.start_i = 1'b1;
    @(negedge clk);                   // cycle 12
    dif.start_i = 1'b0;
    for (int c = 12; c < 45; c++) begin
      if (dif.hilo_write_en_o === REG_ENABLE) pulses++;
      @(negedge clk);
    end
    tests_run++;                      // cycle 45
    if (dif.hilo_write_en_o !== REG_ENABLE) begin fails++; $display("FAIL annul_restart_we: got %b want 1 at cycle 45", dif.hilo_write_en_o); end
    tests_run++;
    if (dif.lo_data_o !== 32'd14 || dif.hi_data_o !== 32'd2) begin
      fails++; $display("FAIL annul_restart_data: got lo %h hi %h want e 2", dif.lo_data_o, dif.hi_data_o);
    end
    tests_run++;
    if (pulses !== 0) begin fails++; $display("FAIL annul_no_write: got %0d early pulses want 0", pulses); end
  endtask

  task automatic test_annul_end();
    logic [31:0] old_hi, old_lo;
    old_hi = dif.hi_data_o;
    old_lo = dif.lo_data_o;
    @(negedge clk);
    dif.dividend_i = 32'd9; dif.divisor_i = 32'd0; dif.signed_i = 1'b0; dif.start_i = 1'b1;
    @(negedge clk);                   // cycle 1
    dif.start_i = 1'b0;
    @(negedge clk);                   // cycle 2: write cycle
    dif.annul_i = 1'b1;
    #1;
    tests_run++;
    if (dif.hilo_write_en_o !== REG_DISABLE) begin fails++; $display("FAIL annul_end_we: got %b want 0", dif.hilo_write_en_o); end
    @(negedge clk);
    dif.annul_i = 1'b0;
    tests_run++;
    if (dif.busy_o !== 1'b0) begin fails++; $display("FAIL annul_end_busy: got %b want 0", dif.busy_o); end
    tests_run++;
    if (dif.hi_data_o !== old_hi || dif.lo_data_o !== old_lo) begin
      fails++; $display("FAIL annul_end_hold: got hi %h lo %h want %h %h", dif.hi_data_o, dif.lo_data_o, old_hi, old_lo);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    dif.dividend_i = 32'h1234_5678; dif.divisor_i = 32'h123; dif.signed_i = 1'b0; dif.start_i = 1'b1;
    @(negedge clk);
    dif.start_i = 1'b0;
    pulses = 0;
    for (int c = 1; c < 20; c++) begin
      if (dif.hilo_write_en_o === REG_ENABLE) pulses++;
      @(negedge clk);
    end
    rst = RST_ENABLE;                 // cycle 20
    @(negedge clk);                   // cycle 21
    rst = RST_DISABLE;
    tests_run++;
    if (dif.busy_o !== 1'b0 || dif.hilo_write_en_o !== REG_DISABLE) begin
      fails++; $display("FAIL rst_mid_ctrl: got busy %b we %b want 0 0", dif.busy_o, dif.hilo_write_en_o);
    end
    tests_run++;
    if (dif.hi_data_o !== 32'd0 || dif.lo_data_o !== 32'd0) begin
      fails++; $display("FAIL rst_mid_data: got hi %h lo %h want 0 0", dif.hi_data_o, dif.lo_data_o);
    end
    for (int c = 0; c < 40; c++) begin
      if (dif.hilo_write_en_o === REG_ENABLE || dif.busy_o === 1'b1) pulses++;
      @(negedge clk);
    end
    tests_run++;
    if (pulses !== 0) begin fails++; $display("FAIL rst_mid_idle: got %0d write/busy cycles want 0", pulses); end
  endtask

  task automatic test_start_ignored();
    int pulses, pcyc;
    logic [31:0] hi, lo;
    hi = 32'hx; lo = 32'hx;
    @(negedge clk);
    dif.dividend_i = 32'd1000; dif.divisor_i = 32'd10; dif.signed_i = 1'b0; dif.start_i = 1'b1;
    @(negedge clk);
    dif.start_i = 1'b0;
    pulses = 0;
    pcyc   = -1;
    for (int c = 1; c <= 80; c++) begin
      dif.start_i = (c == 5 || c == 20);
      if (c == 5 || c == 20) begin
        dif.dividend_i = 32'd50; dif.divisor_i = 32'd0;
      end
      if (dif.hilo_write_en_o === REG_ENABLE) begin
        pulses++;
        pcyc = c;
        hi = dif.hi_data_o;
        lo = dif.lo_data_o;
      end
      @(negedge clk);
    end
    dif.start_i = 1'b0;
    tests_run++;
    if (pulses !== 1) begin fails++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
    tests_run++;
    if (pcyc !== 34) begin fails++; $display("FAIL ignore_cycle: got %0d want 34", pcyc); end
    tests_run++;
    if (lo !== 32'd100 || hi !== 32'd0) begin fails++; $display("FAIL ignore_data: got lo %h hi %h want 64 0", lo, hi); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo;
    int cyc;
    bit bok;
    run_div(32'd200, 32'd9, DIV_UNSIGNED, hi, lo, cyc, bok);
    tests_run++;
    if (lo !== 32'd22 || hi !== 32'd2) begin fails++; $display("FAIL b2b_first: got lo %h hi %h want 16 2", lo, hi); end
    // The next call drives start in the cycle right after the pulse.
    run_div(32'hFFFF_FF9C, 32'd7, DIV_SIGNED, hi, lo, cyc, bok);
    tests_run++;
    if (cyc !== 34) begin fails++; $display("FAIL b2b_latency: got cycle %0d want 34", cyc); end
    tests_run++;
    if (lo !== 32'hFFFF_FFF2 || hi !== 32'hFFFF_FFFE) begin
      fails++; $display("FAIL b2b_second: got lo %h hi %h want fffffff2 fffffffe", lo, hi);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, hi, lo, eq, er;
    logic s;
    int cyc, ecyc;
    bit bok;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        4: b = b >> $urandom_range(1, 31);
        5: a = a >> $urandom_range(1, 31);
        default: ;
      endcase
      ref_div(a, b, s, eq, er);
      ecyc = (b == 32'd0) ? 2 : 34;
      run_div(a, b, s, hi, lo, cyc, bok);
      tests_run++;
      if (cyc !== ecyc) begin fails++; $display("FAIL rand_latency: a=%h b=%h s=%b got cycle %0d want %0d", a, b, s, cyc, ecyc); end
      tests_run++;
      if (lo !== eq) begin fails++; $display("FAIL rand_lo: a=%h b=%h s=%b got %h want %h", a, b, s, lo, eq); end
      tests_run++;
      if (hi !== er) begin fails++; $display("FAIL rand_hi: a=%h b=%h s=%b got %h want %h", a, b, s, hi, er); end
    end
  endtask

  initial begin
    tests_run      = 0;
    fails          = 0;
    rst            = RST_ENABLE;
    dif.start_i    = 1'b0;
    dif.signed_i   = 1'b0;
    dif.annul_i    = 1'b0;
    dif.dividend_i = 32'd0;
    dif.divisor_i  = 32'd0;
    test_reset();
    test_divu_basic();
    test_corner_cases();
    test_annul();
    test_reset_mid();
    test_divu_basic();
    test_annul_end();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
